// File: rtl/rr_arbiter_4_2.sv
// rr_arbiter_4_2: four-way round-robin arbiter with grant locking and bounded hold time
module rr_arbiter_4_2 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit              LIM_EN = MAX_HOLD != 0;
    localparam int              LIM_I  = LIM_EN ? MAX_HOLD - 1 : 0;
    localparam logic [CNT_W-1:0] LIM   = CNT_W'(LIM_I);

    state_t             state, state_nx;
    logic [1:0]         idx_nx, last, last_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [3:0]         others;
    logic [2:0]         win_all, win_oth;

    // Returns {found, index} of the first set bit searching base+1, base+2, base+3, base (mod 4).
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] c;
        pick = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            c = base + i[1:0];
            if (r[c]) pick = {1'b1, c};
        end
    endfunction

    assign others  = req & ~(4'b0001 << gnt_idx);
    assign win_all = pick(req, last);
    assign win_oth = pick(others, last);

    // Next-state: arbitration from idle, hand-over on release, pre-emption on hold timeout.
    always_comb begin
        state_nx = state;
        idx_nx   = gnt_idx;
        last_nx  = last;
        cnt_nx   = cnt;
        if (state == IDLE) begin
            if (win_all[2]) begin
                state_nx = GRANT;
                idx_nx   = win_all[1:0];
                last_nx  = win_all[1:0];
                cnt_nx   = '0;
            end
        end else if (!req[gnt_idx]) begin
            cnt_nx = '0;
            if (win_oth[2]) begin
                idx_nx  = win_oth[1:0];
                last_nx = win_oth[1:0];
            end else begin
                state_nx = IDLE;
                idx_nx   = 2'd0;
            end
        end else if (!win_oth[2]) begin
            cnt_nx = '0;
        end else if (LIM_EN && cnt == LIM) begin
            idx_nx  = win_oth[1:0];
            last_nx = win_oth[1:0];
            cnt_nx  = '0;
        end else begin
            cnt_nx = (cnt == '1) ? cnt : cnt + 1'b1;
        end
    end

    // State and registered outputs; last resets to 3 so req[0] wins the first arbitration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_idx   <= 2'd0;
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            last      <= 2'd3;
            cnt       <= '0;
        end else begin
            state     <= state_nx;
            gnt_idx   <= idx_nx;
            gnt       <= (state_nx == GRANT) ? (4'b0001 << idx_nx) : 4'b0000;
            gnt_valid <= state_nx == GRANT;
            last      <= last_nx;
            cnt       <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_4_2.sv
// tb_rr_arbiter_4_2: directed table-driven bench for rr_arbiter_4_2
module tb_rr_arbiter_4_2;
    logic       clk = 1'b0;
    logic       rst_n, rst_nb;
    logic [3:0] req, req_b, gnt, gnt_b;
    logic [1:0] gnt_idx, gnt_idx_b;
    logic       gnt_valid, gnt_valid_b;

    always #5 clk = ~clk;

    rr_arbiter_4_2 #(.MAX_HOLD(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    rr_arbiter_4_2 #(.MAX_HOLD(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_nb), .req(req_b),
        .gnt(gnt_b), .gnt_idx(gnt_idx_b), .gnt_valid(gnt_valid_b)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] i);
        vec_t v;
        v.rst_n = r;
        v.req   = q;
        v.gnt   = g;
        v.idx   = i;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] i, input logic v,
                         input logic [3:0] eg, input logic [1:0] ei);
        vectors++;
        if ({g, i, v} !== {eg, ei, |eg}) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                     name, g, i, v, eg, ei, |eg);
        end
    endtask

    task automatic step_a(input logic r, input logic [3:0] q, input logic [3:0] eg, input logic [1:0] ei,
                          input string name);
        rst_n = r;
        req   = q;
        @(posedge clk);
        #1;
        check(name, gnt, gnt_idx, gnt_valid, eg, ei);
    endtask

    task automatic step_b(input logic r, input logic [3:0] q, input logic [3:0] eg, input logic [1:0] ei,
                          input string name);
        rst_nb = r;
        req_b  = q;
        @(posedge clk);
        #1;
        check(name, gnt_b, gnt_idx_b, gnt_valid_b, eg, ei);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst_nb = 1'b0;
        req    = 4'b0000;
        req_b  = 4'b0000;
        // reset, first grant, rotation, idle, timeout pre-emption (MAX_HOLD=4)
        add(0, 4'b1111, 4'b0000, 2'd0);
        add(0, 4'b1111, 4'b0000, 2'd0);
        add(1, 4'b1111, 4'b0001, 2'd0);
        add(1, 4'b1110, 4'b0010, 2'd1);
        add(1, 4'b1101, 4'b0100, 2'd2);
        add(1, 4'b1011, 4'b1000, 2'd3);
        add(1, 4'b0000, 4'b0000, 2'd0);
        add(1, 4'b0101, 4'b0001, 2'd0);
        add(1, 4'b0101, 4'b0001, 2'd0);
        add(1, 4'b0101, 4'b0001, 2'd0);
        add(1, 4'b0101, 4'b0001, 2'd0);
        add(1, 4'b0101, 4'b0100, 2'd2);
        add(1, 4'b0101, 4'b0100, 2'd2);
        add(1, 4'b0101, 4'b0100, 2'd2);
        add(1, 4'b0101, 4'b0100, 2'd2);
        add(1, 4'b0101, 4'b0001, 2'd0);
        foreach (tbl[k]) step_a(tbl[k].rst_n, tbl[k].req, tbl[k].gnt, tbl[k].idx, $sformatf("a_vec%0d", k));
        // lone owner is never pre-empted
        for (int n = 0; n < 22; n++) step_a(1, 4'b0001, 4'b0001, 2'd0, $sformatf("solo%0d", n));
        tbl.delete();
        // release with new request, idle and re-grant, reset mid-grant, release at timeout
        add(1, 4'b0100, 4'b0100, 2'd2);
        add(1, 4'b0000, 4'b0000, 2'd0);
        add(1, 4'b0100, 4'b0100, 2'd2);
        add(1, 4'b0010, 4'b0010, 2'd1);
        add(1, 4'b1001, 4'b1000, 2'd3);
        add(0, 4'b1111, 4'b0000, 2'd0);
        add(1, 4'b1111, 4'b0001, 2'd0);
        add(1, 4'b1111, 4'b0001, 2'd0);
        add(1, 4'b1111, 4'b0001, 2'd0);
        add(1, 4'b1111, 4'b0001, 2'd0);
        add(1, 4'b1110, 4'b0010, 2'd1);
        add(1, 4'b1111, 4'b0010, 2'd1);
        add(1, 4'b1111, 4'b0010, 2'd1);
        add(1, 4'b1111, 4'b0010, 2'd1);
        add(1, 4'b1111, 4'b0100, 2'd2);
        foreach (tbl[k]) step_a(tbl[k].rst_n, tbl[k].req, tbl[k].gnt, tbl[k].idx, $sformatf("b_vec%0d", k));
        // MAX_HOLD=0: owner keeps the grant indefinitely, hands over on release
        step_b(0, 4'b0011, 4'b0000, 2'd0, "nolim_rst");
        step_b(1, 4'b0011, 4'b0001, 2'd0, "nolim_first");
        for (int n = 0; n < 50; n++) step_b(1, 4'b0011, 4'b0001, 2'd0, $sformatf("nolim_hold%0d", n));
        step_b(1, 4'b0010, 4'b0010, 2'd1, "nolim_release");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
